addr_decoder_scan: RTL and testbench

Parametrised, registered one-hot select decoder: ADDR_W-bit address to N_OUT select lines, gated by a select enable. Adds a scan mode: an FSM that walks the select lines in order and holds each for PULSE_LEN cycles, with pause and done signalling. Drives chip/row selects in the peripheral address path and supports sequential sweep during bring-up and test.

---
 rtl/addr_decoder_scan.sv | 167 ++++++++++++++++
 tb/tb_addr_decoder_scan.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_decoder_scan.sv
// addr_decoder_scan
// -----------------
// Registered one-hot select decoder with a sequential scan mode.
//
// Direct mode (mode=0 while idle): adr is decoded to a one-hot sel_x one
// cycle later, gated by select. An address outside 0..N_OUT-1 with select=1
// gives sel_x=0 and a one-cycle adr_err pulse.
//
// Scan mode (mode=1 and start=1 while idle): the select lines are walked from
// line 0 to line N_OUT-1. Each line is high for PULSE_LEN consecutive cycles,
// with no gap between lines. select=0 pauses the walk; the current line and
// its remaining count are kept until select returns. A one-cycle done pulse
// follows the last line. sel_x, cur_adr and busy stay aligned: every busy
// cycle with select held high shows the line named by cur_adr.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset, overrides everything
//   mode     0 = direct decode, 1 = scan (sampled only when idle)
//   adr      direct-mode address
//   select   direct: output enable; scan: low = pause
//   start    scan trigger (sampled only when idle with mode=1)
//   sel_x    registered one-hot select, or all zero
//   cur_adr  line being driven (scan) or last decoded address (direct)
//   busy     high while scanning
//   done     one-cycle pulse when a scan finishes
//   adr_err  one-cycle pulse for an out-of-range direct-mode address

module addr_decoder_scan #(
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned N_OUT     = 8,
  parameter int unsigned PULSE_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [ADDR_W-1:0] adr,
  input  logic              select,
  input  logic              start,
  output logic [N_OUT-1:0]  sel_x,
  output logic [ADDR_W-1:0] cur_adr,
  output logic              busy,
  output logic              done,
  output logic              adr_err
);

  // A PULSE_LEN of 1 would give a zero-width counter; keep one bit that
  // simply never leaves zero.
  localparam int unsigned CntW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  localparam logic [CntW-1:0]   CntLast = CntW'(PULSE_LEN - 1);
  localparam logic [ADDR_W-1:0] AdrLast = ADDR_W'(N_OUT - 1);
  // One extra bit so N_OUT == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   NOutExt = (ADDR_W + 1)'(N_OUT);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [N_OUT-1:0]  sel_x_q, sel_x_d;
  logic [ADDR_W-1:0] cur_adr_q, cur_adr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              adr_err_q, adr_err_d;

  logic              adr_in_range;
  logic              line_active;

  // Addresses N_OUT..2**ADDR_W-1 decode to all zero.
  function automatic logic [N_OUT-1:0] decode(input logic [ADDR_W-1:0] a);
    logic [N_OUT-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (a == ADDR_W'(i)) begin
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

  assign adr_in_range = ({1'b0, adr} < NOutExt);

  // A scan cycle counts toward the hold time only if the line was actually
  // driven in it; paused cycles show sel_x=0 and leave the count untouched.
  assign line_active = |sel_x_q;

  always_comb begin
    state_d   = state_q;
    sel_x_d   = '0;
    cur_adr_d = cur_adr_q;
    cnt_d     = cnt_q;
    adr_err_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (mode) begin
          // Scan request wins over direct decode in this cycle.
          if (start) begin
            state_d   = StScan;
            cur_adr_d = '0;
            cnt_d     = '0;
            // Line 0 goes out together with busy so that the two stay aligned.
            if (select) begin
              sel_x_d = decode('0);
            end
          end
        end else if (select) begin
          cur_adr_d = adr;
          if (adr_in_range) begin
            sel_x_d = decode(adr);
          end else begin
            adr_err_d = 1'b1;
          end
        end
      end

      StScan: begin
        if (line_active) begin
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            if (cur_adr_q == AdrLast) begin
              state_d = StDone;
            end else begin
              cur_adr_d = cur_adr_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if ((state_d == StScan) && select) begin
          sel_x_d = decode(cur_adr_d);
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sel_x_q   <= '0;
      cur_adr_q <= '0;
      cnt_q     <= '0;
      adr_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_x_q   <= sel_x_d;
      cur_adr_q <= cur_adr_d;
      cnt_q     <= cnt_d;
      adr_err_q <= adr_err_d;
    end
  end

  assign sel_x   = sel_x_q;
  assign cur_adr = cur_adr_q;
  assign busy    = (state_q == StScan);
  assign done    = (state_q == StDone);
  assign adr_err = adr_err_q;

endmodule

// File: tb/tb_addr_decoder_scan.sv
// Bench for addr_decoder_scan. Two instances share the same stimulus:
//   u_dut8: ADDR_W=3, N_OUT=8, PULSE_LEN=4
//   u_dut6: ADDR_W=3, N_OUT=6, PULSE_LEN=1 (out-of-range addresses, 1-cycle hold)
// The reference model tracks a scan as a linear count of driven cycles;
// the current line is that count divided by the hold length.

module tb_addr_decoder_scan;

  logic       clk;
  logic       rst;
  logic       mode;
  logic [2:0] adr;
  logic       select;
  logic       start;

  logic [7:0] sel8;
  logic [2:0] cur8;
  logic       busy8, done8, err8;
  logic [5:0] sel6;
  logic [2:0] cur6;
  logic       busy6, done6, err6;

  int n_assert = 0;
  int n_fail   = 0;
  int busy_cnt = 0;

  int unsigned NOUT [2] = '{8, 6};
  int unsigned PLEN [2] = '{4, 1};

  // Model state: phase 0 idle, 1 scanning, 2 done.
  int         ph   [2];
  int         pos  [2];
  int         mcur [2];
  logic [7:0] msel [2];
  logic       merr [2];

  addr_decoder_scan #(
    .ADDR_W   (3),
    .N_OUT    (8),
    .PULSE_LEN(4)
  ) u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .adr    (adr),
    .select (select),
    .start  (start),
    .sel_x  (sel8),
    .cur_adr(cur8),
    .busy   (busy8),
    .done   (done8),
    .adr_err(err8)
  );

  addr_decoder_scan #(
    .ADDR_W   (3),
    .N_OUT    (6),
    .PULSE_LEN(1)
  ) u_dut6 (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .adr    (adr),
    .select (select),
    .start  (start),
    .sel_x  (sel6),
    .cur_adr(cur6),
    .busy   (busy6),
    .done   (done6),
    .adr_err(err6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k);
    int n;
    int p;
    n = int'(NOUT[k]);
    p = int'(PLEN[k]);
    if (rst) begin
      ph[k] = 0; pos[k] = 0; mcur[k] = 0; msel[k] = 8'h00; merr[k] = 1'b0;
    end else begin
      case (ph[k])
        0: begin
          merr[k] = 1'b0;
          msel[k] = 8'h00;
          if (mode) begin
            if (start) begin
              ph[k] = 1; pos[k] = 0; mcur[k] = 0;
              if (select) msel[k] = 8'h01;
            end
          end else if (select) begin
            mcur[k] = int'(adr);
            if (int'(adr) < n) msel[k] = 8'h01 << adr;
            else merr[k] = 1'b1;
          end
        end
        1: begin
          merr[k] = 1'b0;
          if (msel[k] != 8'h00) pos[k]++;
          if (pos[k] == n * p) begin
            ph[k] = 2; msel[k] = 8'h00; mcur[k] = n - 1;
          end else begin
            mcur[k] = pos[k] / p;
            msel[k] = select ? (8'h01 << mcur[k]) : 8'h00;
          end
        end
        default: begin
          ph[k] = 0; msel[k] = 8'h00; merr[k] = 1'b0;
        end
      endcase
    end
  endtask

  task automatic check_all();
    chk("sel_x8",   32'(sel8),  32'(msel[0]));
    chk("cur_adr8", 32'(cur8),  32'(mcur[0]));
    chk("busy8",    32'(busy8), 32'(ph[0] == 1));
    chk("done8",    32'(done8), 32'(ph[0] == 2));
    chk("adr_err8", 32'(err8),  32'(merr[0]));
    chk("sel_x6",   32'(sel6),  32'(msel[1]));
    chk("cur_adr6", 32'(cur6),  32'(mcur[1]));
    chk("busy6",    32'(busy6), 32'(ph[1] == 1));
    chk("done6",    32'(done6), 32'(ph[1] == 2));
    chk("adr_err6", 32'(err6),  32'(merr[1]));
    chk("onehot8",  32'($onehot0(sel8)), 32'd1);
    chk("onehot6",  32'($onehot0(sel6)), 32'd1);
    chk("err_done8", 32'(err8 & done8), 32'd0);
    if (busy8) busy_cnt++;
  endtask

  // Advance one clock: model samples the same inputs as the DUTs at the
  // rising edge, outputs are compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_done8();
    for (int i = 0; i < 100; i++) begin
      if (done8) break;
      cycle();
    end
    chk("done_seen8", 32'(done8), 32'd1);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; adr = 3'd0; select = 1'b0; start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; pos[k] = 0; mcur[k] = 0; msel[k] = 8'h00; merr[k] = 1'b0;
    end

    // Reset
    cycle();
    cycle();
    chk("reset_sel8", 32'(sel8), 32'd0);
    rst = 1'b0;

    // Direct sweep 0..7
    select = 1'b1;
    for (int i = 0; i < 8; i++) begin
      adr = 3'(i);
      cycle();
      chk("sweep_sel8", 32'(sel8), 32'd1 << i);
      chk("sweep_err8", 32'(err8), 32'd0);
    end

    // Select gating: cur_adr keeps 7 from the sweep
    adr = 3'd5; select = 1'b0;
    cycle();
    cycle();
    chk("gate_sel8", 32'(sel8), 32'd0);
    chk("gate_cur8", 32'(cur8), 32'd7);
    select = 1'b1;
    cycle();
    chk("ungate_sel8", 32'(sel8), 32'h20);

    // Out of range on the 6-output instance
    adr = 3'd7;
    cycle();
    chk("oor_err6", 32'(err6), 32'd1);
    chk("oor_sel6", 32'(sel6), 32'd0);
    chk("oor_cur6", 32'(cur6), 32'd7);
    adr = 3'd0;
    cycle();
    chk("oor_pulse6", 32'(err6), 32'd0);

    // Full scan
    busy_cnt = 0;
    mode = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("scan_first8", 32'(sel8), 32'h01);
    wait_done8();
    chk("scan_len8", 32'(busy_cnt), 32'd32);
    cycle();
    chk("scan_idle8", 32'(busy8 | done8), 32'd0);

    // Pause on line 3 after 2 cycles, with a start pulse during the pause
    busy_cnt = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (13) cycle();
    chk("pause_line8", 32'(sel8), 32'h08);
    select = 1'b0;
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    select = 1'b1;
    wait_done8();
    chk("pause_len8", 32'(busy_cnt), 32'd37);
    cycle();

    // Reset mid-scan
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (16) cycle();
    chk("mid_line8", 32'(sel8), 32'h10);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_cur8",  32'(cur8),  32'd0);
    chk("rst_sel8",  32'(sel8),  32'd0);
    repeat (5) cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("restart_sel8", 32'(sel8), 32'h01);
    wait_done8();
    cycle();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 59) == 0);
      mode   = ($urandom_range(0, 2) != 0);
      adr    = 3'($urandom);
      select = ($urandom_range(0, 4) != 0);
      start  = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
